ccip_mmio_rsp: RTL and testbench



---
 rtl/ccip_mmio_pkg.sv | 48 ++++
 rtl/ccip_mmio_regs.sv | 72 +++++++
 rtl/ccip_mmio_rsp.sv | 86 ++++++++
 tb/tb_ccip_mmio_rsp.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_mmio_pkg.sv
// Shared MMIO definitions for the CCI-P MMIO responder: DWORD register addresses,
// access-length encoding and the sub-word write-merge helper.
package ccip_mmio_pkg;

  localparam logic [15:0] AddrDfh      = 16'h0000;
  localparam logic [15:0] AddrAfuIdL   = 16'h0002;
  localparam logic [15:0] AddrAfuIdH   = 16'h0004;
  localparam logic [15:0] AddrRsvd0    = 16'h0006;
  localparam logic [15:0] AddrRsvd1    = 16'h0008;
  localparam logic [15:0] AddrScratch0 = 16'h0010;
  localparam logic [15:0] AddrScratch1 = 16'h0012;
  localparam logic [15:0] AddrCycleCnt = 16'h0014;
  localparam logic [15:0] AddrWrCnt    = 16'h0016;

  // 64-bit register index: DWORD address without the half-select bit.
  localparam logic [14:0] QwDfh      = AddrDfh[15:1];
  localparam logic [14:0] QwAfuIdL   = AddrAfuIdL[15:1];
  localparam logic [14:0] QwAfuIdH   = AddrAfuIdH[15:1];
  localparam logic [14:0] QwRsvd0    = AddrRsvd0[15:1];
  localparam logic [14:0] QwRsvd1    = AddrRsvd1[15:1];
  localparam logic [14:0] QwScratch0 = AddrScratch0[15:1];
  localparam logic [14:0] QwScratch1 = AddrScratch1[15:1];
  localparam logic [14:0] QwCycleCnt = AddrCycleCnt[15:1];
  localparam logic [14:0] QwWrCnt    = AddrWrCnt[15:1];

  // Only Len4B selects a DWORD access; every other code is an 8B access.
  typedef enum logic [1:0] {
    Len4B = 2'd0,
    Len8B = 2'd1
  } mmio_len_e;

  function automatic logic is_dword(input logic [1:0] len);
    return len == Len4B;
  endfunction

  function automatic logic [63:0] merge_write(input logic [63:0] old_val,
                                              input logic [63:0] data,
                                              input logic [1:0]  len,
                                              input logic        hi);
    logic [63:0] res;
    res = data;
    if (is_dword(len)) begin
      res = hi ? {data[31:0], old_val[31:0]} : {old_val[63:32], data[31:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ccip_mmio_regs.sv
// MMIO register file: read-only identity registers, two scratch registers,
// free-running cycle counter and write counter, with write decode and read select.
module ccip_mmio_regs
  import ccip_mmio_pkg::*;
#(
  parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_valid_i,
  input  logic [15:0] wr_addr_i,
  input  logic [1:0]  wr_len_i,
  input  logic [63:0] wr_data_i,
  input  logic [14:0] rd_qidx_i,
  output logic [63:0] rd_data_o
);

  logic [63:0] scratch0_q, scratch0_d;
  logic [63:0] scratch1_q, scratch1_d;
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    scratch0_d  = scratch0_q;
    scratch1_d  = scratch1_q;
    cycle_cnt_d = cycle_cnt_q + 64'd1;
    wr_cnt_d    = wr_cnt_q;
    if (wr_valid_i) begin
      // Counts every write strobe, including writes to RO or unmapped addresses.
      wr_cnt_d = wr_cnt_q + 16'd1;
      if (wr_addr_i[15:1] == QwScratch0) begin
        scratch0_d = merge_write(scratch0_q, wr_data_i, wr_len_i, wr_addr_i[0]);
      end
      if (wr_addr_i[15:1] == QwScratch1) begin
        scratch1_d = merge_write(scratch1_q, wr_data_i, wr_len_i, wr_addr_i[0]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scratch0_q  <= 64'h0;
      scratch1_q  <= 64'h0;
      cycle_cnt_q <= 64'h0;
      wr_cnt_q    <= 16'h0;
    end else begin
      scratch0_q  <= scratch0_d;
      scratch1_q  <= scratch1_d;
      cycle_cnt_q <= cycle_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  always_comb begin
    rd_data_o = 64'h0;
    case (rd_qidx_i)
      QwDfh:      rd_data_o = DFH_VALUE;
      QwAfuIdL:   rd_data_o = AFU_ID_L;
      QwAfuIdH:   rd_data_o = AFU_ID_H;
      QwRsvd0:    rd_data_o = 64'h0;
      QwRsvd1:    rd_data_o = 64'h0;
      QwScratch0: rd_data_o = scratch0_q;
      QwScratch1: rd_data_o = scratch1_q;
      QwCycleCnt: rd_data_o = cycle_cnt_q;
      QwWrCnt:    rd_data_o = {48'h0, wr_cnt_q};
      default:    rd_data_o = 64'h0;
    endcase
  end

endmodule

// File: rtl/ccip_mmio_rsp.sv
// CCI-P MMIO responder: two-stage read pipeline (request capture, then data select)
// feeding a registered c2 response; fixed 2-cycle latency, no backpressure.
module ccip_mmio_rsp
  import ccip_mmio_pkg::*;
#(
  parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0
) (
  input  logic        pClk,
  input  logic        SoftReset,
  input  logic        rd_valid,
  input  logic [8:0]  rd_tid,
  input  logic [15:0] rd_addr,
  input  logic [1:0]  rd_len,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [1:0]  wr_len,
  input  logic [63:0] wr_data,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data
);

  logic        s1_valid_q;
  logic [8:0]  s1_tid_q;
  logic [15:0] s1_addr_q;
  logic [1:0]  s1_len_q;
  logic [63:0] reg_data;

  logic        rsp_valid_q;
  logic [8:0]  rsp_tid_q;
  logic [63:0] rsp_data_q, rsp_data_d;

  ccip_mmio_regs #(
    .DFH_VALUE (DFH_VALUE),
    .AFU_ID_L  (AFU_ID_L),
    .AFU_ID_H  (AFU_ID_H)
  ) u_regs (
    .clk_i      (pClk),
    .rst_i      (SoftReset),
    .wr_valid_i (wr_valid),
    .wr_addr_i  (wr_addr),
    .wr_len_i   (wr_len),
    .wr_data_i  (wr_data),
    .rd_qidx_i  (s1_addr_q[15:1]),
    .rd_data_o  (reg_data)
  );

  always_comb begin
    rsp_data_d = reg_data;
    if (is_dword(s1_len_q)) begin
      rsp_data_d = {32'h0, s1_addr_q[0] ? reg_data[63:32] : reg_data[31:0]};
    end
  end

  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      s1_valid_q  <= 1'b0;
      s1_tid_q    <= 9'h0;
      s1_addr_q   <= 16'h0;
      s1_len_q    <= 2'h0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= 9'h0;
      rsp_data_q  <= 64'h0;
    end else begin
      s1_valid_q  <= rd_valid;
      rsp_valid_q <= s1_valid_q;
      if (rd_valid) begin
        s1_tid_q  <= rd_tid;
        s1_addr_q <= rd_addr;
        s1_len_q  <= rd_len;
      end
      // Payload holds its last value between responses.
      if (s1_valid_q) begin
        rsp_tid_q  <= s1_tid_q;
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ccip_mmio_rsp.sv
// Directed self-checking bench for ccip_mmio_rsp.
module tb_ccip_mmio_rsp;

  localparam logic [63:0] Dfh  = 64'h1000_0000_0000_1000;
  localparam logic [63:0] IdL  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IdH  = 64'hFEDC_BA98_7654_3210;

  logic        pClk;
  logic        SoftReset;
  logic        rd_valid;
  logic [8:0]  rd_tid;
  logic [15:0] rd_addr;
  logic [1:0]  rd_len;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [1:0]  wr_len;
  logic [63:0] wr_data;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  int checks = 0;
  int errors = 0;

  logic        got_v;
  logic [8:0]  got_t;
  logic [63:0] got_d;

  ccip_mmio_rsp #(
    .DFH_VALUE (Dfh),
    .AFU_ID_L  (IdL),
    .AFU_ID_H  (IdH)
  ) dut (
    .pClk      (pClk),
    .SoftReset (SoftReset),
    .rd_valid  (rd_valid),
    .rd_tid    (rd_tid),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_len    (wr_len),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_tid   (rsp_tid),
    .rsp_data  (rsp_data)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic apply_reset();
    SoftReset = 1'b1;
    tick();
    tick();
    SoftReset = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_len   = l;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Issues one read and captures the output two cycles later.
  task automatic rd(input logic [8:0] t, input logic [15:0] a, input logic [1:0] l);
    rd_valid = 1'b1;
    rd_tid   = t;
    rd_addr  = a;
    rd_len   = l;
    tick();
    rd_valid = 1'b0;
    tick();
    got_v = rsp_valid;
    got_t = rsp_tid;
    got_d = rsp_data;
  endtask

  task automatic test_reset();
    SoftReset = 1'b1;
    rd_valid = 1'b1; rd_tid = 9'h1FF; rd_addr = 16'h0; rd_len = 2'd1;
    wr_valid = 1'b1; wr_addr = 16'h0010; wr_len = 2'd1; wr_data = 64'hFFFF;
    tick(); tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_tid !== 9'h0 || rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b tid=%h data=%h want 0/0/0",
               rsp_valid, rsp_tid, rsp_data);
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    SoftReset = 1'b0;
    // Scratch must be clear although a write was presented during reset.
    rd(9'h0A, 16'h0010, 2'd1);
    checks++;
    if (got_v !== 1'b1 || got_d !== 64'h0) begin
      errors++;
      $display("FAIL reset_scratch0: got v=%b data=%h want 1/0", got_v, got_d);
    end
  endtask

  task automatic test_dfh();
    rd_valid = 1'b1; rd_tid = 9'h05; rd_addr = 16'h0000; rd_len = 2'd1;
    tick();
    rd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dfh_latency_n1: rsp_valid got %b want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h05 || rsp_data !== Dfh) begin
      errors++;
      $display("FAIL dfh_read: got v=%b tid=%h data=%h want 1/005/%h",
               rsp_valid, rsp_tid, rsp_data, Dfh);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dfh_single_pulse: rsp_valid got %b want 0", rsp_valid);
    end
    rd(9'h06, 16'h0001, 2'd0);
    checks++;
    if (got_d !== 64'h0000_0000_1000_0000) begin
      errors++;
      $display("FAIL dfh_4b_hi: got %h want 0000000010000000", got_d);
    end
    rd(9'h07, 16'h0004, 2'd0);
    checks++;
    if (got_d !== 64'h0000_0000_7654_3210) begin
      errors++;
      $display("FAIL afuidh_4b_lo: got %h want 0000000076543210", got_d);
    end
  endtask

  task automatic test_scratch();
    wr(16'h0010, 2'd1, 64'hDEAD_BEEF_0123_4567);
    wr(16'h0011, 2'd0, 64'hFFFF_FFFF_CAFE_F00D);
    rd(9'h10, 16'h0010, 2'd1);
    checks++;
    if (got_v !== 1'b1 || got_t !== 9'h10 || got_d !== 64'hCAFE_F00D_0123_4567) begin
      errors++;
      $display("FAIL scratch_8b: got v=%b tid=%h data=%h want 1/010/cafef00d01234567",
               got_v, got_t, got_d);
    end
    rd(9'h11, 16'h0011, 2'd0);
    checks++;
    if (got_d !== 64'h0000_0000_CAFE_F00D) begin
      errors++;
      $display("FAIL scratch_4b_hi: got %h want 00000000cafef00d", got_d);
    end
    rd(9'h12, 16'h0010, 2'd0);
    checks++;
    if (got_d !== 64'h0000_0000_0123_4567) begin
      errors++;
      $display("FAIL scratch_4b_lo: got %h want 0000000001234567", got_d);
    end
    rd(9'h13, 16'h0010, 2'd3);
    checks++;
    if (got_d !== 64'hCAFE_F00D_0123_4567) begin
      errors++;
      $display("FAIL scratch_len3_as_8b: got %h want cafef00d01234567", got_d);
    end
  endtask

  task automatic test_ro();
    wr(16'h0002, 2'd1, 64'h1111_1111_1111_1111);
    wr(16'h0020, 2'd1, 64'h2222_2222_2222_2222);
    rd(9'h20, 16'h0002, 2'd1);
    checks++;
    if (got_d !== IdL) begin
      errors++;
      $display("FAIL ro_afuidl: got %h want %h", got_d, IdL);
    end
    rd(9'h21, 16'h0020, 2'd1);
    checks++;
    if (got_d !== 64'h0) begin
      errors++;
      $display("FAIL unmapped_zero: got %h want 0", got_d);
    end
  endtask

  task automatic test_back_to_back();
    wr(16'h0012, 2'd1, 64'h1111_2222_3333_4444);
    wr(16'h0012, 2'd0, 64'h0000_0000_AAAA_BBBB);
    rd_valid = 1'b1; rd_len = 2'd1;
    rd_tid = 9'd1; rd_addr = 16'h0002;
    tick();
    rd_tid = 9'd2; rd_addr = 16'h0020;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'd1 || rsp_data !== IdL) begin
      errors++;
      $display("FAIL b2b_rsp1: got v=%b tid=%h data=%h want 1/001/%h",
               rsp_valid, rsp_tid, rsp_data, IdL);
    end
    rd_tid = 9'd3; rd_addr = 16'h0012;
    tick();
    rd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'd2 || rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL b2b_rsp2: got v=%b tid=%h data=%h want 1/002/0",
               rsp_valid, rsp_tid, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'd3 || rsp_data !== 64'h1111_2222_AAAA_BBBB) begin
      errors++;
      $display("FAIL b2b_rsp3: got v=%b tid=%h data=%h want 1/003/11112222aaaabbbb",
               rsp_valid, rsp_tid, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_same_cycle();
    wr_valid = 1'b1; wr_addr = 16'h0012; wr_len = 2'd1; wr_data = 64'h55;
    rd_valid = 1'b1; rd_tid = 9'h33; rd_addr = 16'h0012; rd_len = 2'd1;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h33 || rsp_data !== 64'h55) begin
      errors++;
      $display("FAIL same_cycle: got v=%b tid=%h data=%h want 1/033/55",
               rsp_valid, rsp_tid, rsp_data);
    end
  endtask

  task automatic test_counters();
    apply_reset();
    wr_valid = 1'b1; wr_addr = 16'h0000; wr_len = 2'd1; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (65535) tick();
    wr_valid = 1'b0;
    rd(9'h40, 16'h0016, 2'd1);
    checks++;
    if (got_d !== 64'hFFFF) begin
      errors++;
      $display("FAIL wrcnt_ffff: got %h want ffff", got_d);
    end
    wr(16'h0000, 2'd1, 64'h0);
    wr(16'h0000, 2'd0, 64'h0);
    rd(9'h41, 16'h0016, 2'd1);
    checks++;
    if (got_d !== 64'h1) begin
      errors++;
      $display("FAIL wrcnt_wrap: got %h want 1", got_d);
    end
    rd(9'h42, 16'h0000, 2'd1);
    checks++;
    if (got_d !== Dfh) begin
      errors++;
      $display("FAIL dfh_unchanged: got %h want %h", got_d, Dfh);
    end
  endtask

  task automatic test_reset_mid_op();
    wr(16'h0010, 2'd1, 64'h1234);
    rd_valid = 1'b1; rd_tid = 9'h77; rd_addr = 16'h0000; rd_len = 2'd1;
    tick();
    rd_valid = 1'b0;
    SoftReset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: rsp_valid got %b want 0", rsp_valid);
    end
    #1;
    SoftReset = 1'b0;
    // Cycle-counter read presented in the first cycle after deassertion.
    rd_valid = 1'b1; rd_tid = 9'h78; rd_addr = 16'h0014; rd_len = 2'd1;
    tick();
    rd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dropped: rsp_valid got %b tid=%h want 0", rsp_valid, rsp_tid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h78 || rsp_data !== 64'h1) begin
      errors++;
      $display("FAIL midrst_cyclecnt: got v=%b tid=%h data=%h want 1/078/1",
               rsp_valid, rsp_tid, rsp_data);
    end
    rd(9'h79, 16'h0010, 2'd1);
    checks++;
    if (got_v !== 1'b1 || got_d !== 64'h0) begin
      errors++;
      $display("FAIL midrst_scratch0: got v=%b data=%h want 1/0", got_v, got_d);
    end
  endtask

  initial begin
    test_reset();
    test_dfh();
    test_scratch();
    test_ro();
    test_back_to_back();
    test_same_cycle();
    test_counters();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
